// File: rtl/alu_operand_stage_pkg.sv
// Shared constants for the ALU operand stage: opcodes, widths and flag bit positions.
package alu_operand_stage_pkg;

    localparam int unsigned AluDataW = 32;
    localparam int unsigned AluRegN  = 32;
    localparam int unsigned RegIdxW  = 5;
    localparam int unsigned OpcodeW  = 6;
    localparam int unsigned ImmW     = 16;
    localparam int unsigned FlagW    = 4;

    // statusFlags is packed {N,Z,C,V}
    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagV = 0;

    typedef enum logic [OpcodeW-1:0] {
        OpAdd   = 6'b000000,
        OpSub   = 6'b000001,
        OpAnd   = 6'b000010,
        OpOr    = 6'b000011,
        OpXor   = 6'b000100,
        OpAddiu = 6'b000101,
        OpSll   = 6'b000110,
        OpSrl   = 6'b000111,
        OpAddi  = 6'b001000,
        OpNor   = 6'b001001,
        OpAndi  = 6'b001010,
        OpOri   = 6'b001011,
        OpXori  = 6'b001100
    } alu_op_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Instruction, writeback, flag and operand-output bundle between upstream and the operand stage.
interface alu_operand_stage_if
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W = AluDataW
);
    logic                inValid;
    logic                stall;
    logic                flush;
    logic [OpcodeW-1:0]  opcodeIn;
    logic [RegIdxW-1:0]  rs;
    logic [RegIdxW-1:0]  rt;
    logic                useImm;
    logic                immSigned;
    logic [ImmW-1:0]     imm;
    logic                wbEnable;
    logic [RegIdxW-1:0]  wbAddr;
    logic [DATA_W-1:0]   wbData;
    logic                flagLoad;
    logic                negativeFlag;
    logic                zeroFlag;
    logic                carryFlag;
    logic                overflowFlag;
    logic [DATA_W-1:0]   A;
    logic [DATA_W-1:0]   B;
    logic [OpcodeW-1:0]  opcode;
    logic                outValid;
    logic                inputCarry;
    logic [FlagW-1:0]    statusFlags;

    modport master (
        output inValid, stall, flush, opcodeIn, rs, rt, useImm, immSigned, imm,
        output wbEnable, wbAddr, wbData, flagLoad,
        output negativeFlag, zeroFlag, carryFlag, overflowFlag,
        input  A, B, opcode, outValid, inputCarry, statusFlags
    );

    modport slave (
        input  inValid, stall, flush, opcodeIn, rs, rt, useImm, immSigned, imm,
        input  wbEnable, wbAddr, wbData, flagLoad,
        input  negativeFlag, zeroFlag, carryFlag, overflowFlag,
        output A, B, opcode, outValid, inputCarry, statusFlags
    );

endinterface

// File: rtl/register_file.sv
// Two asynchronous read ports, one synchronous write port; entry 0 is hardwired to zero.
module register_file
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W = AluDataW,
    parameter int unsigned REG_N  = AluRegN
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [RegIdxW-1:0] raddr_a_i,
    input  logic [RegIdxW-1:0] raddr_b_i,
    output logic [DATA_W-1:0]  rdata_a_o,
    output logic [DATA_W-1:0]  rdata_b_o,
    input  logic               we_i,
    input  logic [RegIdxW-1:0] waddr_i,
    input  logic [DATA_W-1:0]  wdata_i
);

    logic [DATA_W-1:0] mem_q [REG_N];
    logic [DATA_W-1:0] mem_d [REG_N];

    always_comb begin
        mem_d = mem_q;
        if (we_i && (waddr_i != '0)) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Reads and bypasses ALU operands, registers them with flush/stall control, and stores ALU flags.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W = AluDataW,
    parameter int unsigned REG_N  = AluRegN
) (
    input logic               clk,
    input logic               reset,
    alu_operand_stage_if.slave bus
);

    logic [DATA_W-1:0]  rf_rdata_a, rf_rdata_b;
    logic [DATA_W-1:0]  rs_val, rt_val, imm_ext, b_src;
    logic               wb_live;

    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [OpcodeW-1:0] opcode_q, opcode_d;
    logic               valid_q, valid_d;
    logic [RegIdxW-1:0] rs_q, rs_d, rt_q, rt_d;
    logic               use_imm_q, use_imm_d;
    logic [FlagW-1:0]   flags_q, flags_d;

    register_file #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_register_file (
        .clk_i     (clk),
        .rst_i     (reset),
        .raddr_a_i (bus.rs),
        .raddr_b_i (bus.rt),
        .rdata_a_o (rf_rdata_a),
        .rdata_b_o (rf_rdata_b),
        .we_i      (bus.wbEnable),
        .waddr_i   (bus.wbAddr),
        .wdata_i   (bus.wbData)
    );

    assign wb_live = bus.wbEnable && (bus.wbAddr != '0);
    assign rs_val  = (wb_live && (bus.wbAddr == bus.rs)) ? bus.wbData : rf_rdata_a;
    assign rt_val  = (wb_live && (bus.wbAddr == bus.rt)) ? bus.wbData : rf_rdata_b;
    assign imm_ext = bus.immSigned ? {{(DATA_W-ImmW){bus.imm[ImmW-1]}}, bus.imm}
                                   : {{(DATA_W-ImmW){1'b0}}, bus.imm};
    assign b_src   = bus.useImm ? imm_ext : rt_val;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        opcode_d  = opcode_q;
        valid_d   = valid_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        use_imm_d = use_imm_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (bus.stall) begin
            // A held instruction must not go stale while it waits on a writeback it depends on.
            if (valid_q && wb_live && (bus.wbAddr == rs_q)) begin
                a_d = bus.wbData;
            end
            if (valid_q && !use_imm_q && wb_live && (bus.wbAddr == rt_q)) begin
                b_d = bus.wbData;
            end
        end else begin
            a_d       = rs_val;
            b_d       = b_src;
            opcode_d  = bus.opcodeIn;
            valid_d   = bus.inValid;
            rs_d      = bus.rs;
            rt_d      = bus.rt;
            use_imm_d = bus.useImm;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (bus.flagLoad) begin
            flags_d[FlagN] = bus.negativeFlag;
            flags_d[FlagZ] = bus.zeroFlag;
            flags_d[FlagC] = bus.carryFlag;
            flags_d[FlagV] = bus.overflowFlag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            opcode_q  <= '0;
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            use_imm_q <= 1'b0;
            flags_q   <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            opcode_q  <= opcode_d;
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            use_imm_q <= use_imm_d;
            flags_q   <= flags_d;
        end
    end

    assign bus.A           = a_q;
    assign bus.B           = b_q;
    assign bus.opcode      = opcode_q;
    assign bus.outValid    = valid_q;
    assign bus.inputCarry  = flags_q[FlagC];
    assign bus.statusFlags = flags_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with hand-computed expected values.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    alu_operand_stage_if #(.DATA_W(32)) bus_if ();

    alu_operand_stage #(
        .DATA_W (32),
        .REG_N  (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_A"}, bus_if.A, 32'h0);
        check({tag, "_B"}, bus_if.B, 32'h0);
        check({tag, "_opcode"}, 32'(bus_if.opcode), 32'h0);
        check({tag, "_outValid"}, 32'(bus_if.outValid), 32'h0);
        check({tag, "_flags"}, 32'(bus_if.statusFlags), 32'h0);
        check({tag, "_carry"}, 32'(bus_if.inputCarry), 32'h0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus_if.inValid = 0; bus_if.stall = 0; bus_if.flush = 0;
        bus_if.opcodeIn = '0; bus_if.rs = '0; bus_if.rt = '0;
        bus_if.useImm = 0; bus_if.immSigned = 0; bus_if.imm = '0;
        bus_if.wbEnable = 0; bus_if.wbAddr = '0; bus_if.wbData = '0;
        bus_if.flagLoad = 0; bus_if.negativeFlag = 0; bus_if.zeroFlag = 0;
        bus_if.carryFlag = 0; bus_if.overflowFlag = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Fill R5, R6
        bus_if.wbEnable = 1; bus_if.wbAddr = 5; bus_if.wbData = 32'h6;
        tick();
        check("idle_outValid", 32'(bus_if.outValid), 32'h0);
        bus_if.wbAddr = 6; bus_if.wbData = 32'hA;
        tick();
        bus_if.wbEnable = 0;

        // Basic register operands
        bus_if.inValid = 1; bus_if.rs = 5; bus_if.rt = 6; bus_if.opcodeIn = OpAdd;
        tick();
        check("rr_A", bus_if.A, 32'h6);
        check("rr_B", bus_if.B, 32'hA);
        check("rr_opcode", 32'(bus_if.opcode), 32'h0);
        check("rr_outValid", 32'(bus_if.outValid), 32'h1);

        // Same-cycle writeback bypass
        bus_if.wbEnable = 1; bus_if.wbAddr = 7; bus_if.wbData = 32'h12345678;
        bus_if.rs = 7; bus_if.rt = 5; bus_if.opcodeIn = OpSub;
        tick();
        check("bypass_A", bus_if.A, 32'h12345678);
        check("bypass_B", bus_if.B, 32'h6);
        check("bypass_opcode", 32'(bus_if.opcode), 32'h1);
        bus_if.wbEnable = 0;

        // Immediate extension
        bus_if.rs = 6; bus_if.useImm = 1; bus_if.imm = 16'hFFF0; bus_if.immSigned = 1;
        bus_if.opcodeIn = OpAddi;
        tick();
        check("simm_A", bus_if.A, 32'hA);
        check("simm_B", bus_if.B, 32'hFFFFFFF0);
        bus_if.immSigned = 0; bus_if.opcodeIn = OpAndi;
        tick();
        check("zimm_B", bus_if.B, 32'h0000FFF0);
        check("zimm_opcode", 32'(bus_if.opcode), 32'h0A);

        // R0 stays zero, no bypass from a write to index 0
        bus_if.useImm = 0; bus_if.rs = 0; bus_if.rt = 0;
        bus_if.wbEnable = 1; bus_if.wbAddr = 0; bus_if.wbData = 32'hDEADBEEF;
        tick();
        check("r0_bypass_A", bus_if.A, 32'h0);
        check("r0_bypass_B", bus_if.B, 32'h0);
        bus_if.wbEnable = 0;
        tick();
        check("r0_read_A", bus_if.A, 32'h0);

        // Stall with refresh of held operands; new input dropped
        bus_if.rs = 5; bus_if.rt = 6; bus_if.opcodeIn = OpOr;
        tick();
        check("pre_stall_A", bus_if.A, 32'h6);
        bus_if.stall = 1; bus_if.rs = 6; bus_if.rt = 5; bus_if.opcodeIn = OpXor;
        bus_if.wbEnable = 1; bus_if.wbAddr = 5; bus_if.wbData = 32'h55;
        tick();
        check("stall_refresh_A", bus_if.A, 32'h55);
        check("stall_hold_B", bus_if.B, 32'hA);
        check("stall_hold_opcode", 32'(bus_if.opcode), 32'h03);
        check("stall_outValid", 32'(bus_if.outValid), 32'h1);
        bus_if.wbAddr = 6; bus_if.wbData = 32'h66;
        tick();
        check("stall_refresh_B", bus_if.B, 32'h66);
        check("stall_keep_A", bus_if.A, 32'h55);
        bus_if.wbEnable = 0; bus_if.flush = 1;
        tick();
        check("flush_outValid", 32'(bus_if.outValid), 32'h0);
        check("flush_keep_A", bus_if.A, 32'h55);
        bus_if.flush = 0; bus_if.stall = 0; bus_if.inValid = 0;
        tick();
        check("bubble_outValid", 32'(bus_if.outValid), 32'h0);

        // Held immediate B must ignore writebacks to its rt
        bus_if.inValid = 1; bus_if.useImm = 1; bus_if.imm = 16'h0003; bus_if.rs = 5;
        bus_if.rt = 9;
        tick();
        check("imm_hold_A", bus_if.A, 32'h55);
        check("imm_hold_B0", bus_if.B, 32'h3);
        bus_if.stall = 1; bus_if.wbEnable = 1; bus_if.wbAddr = 9; bus_if.wbData = 32'h99;
        tick();
        check("imm_hold_B1", bus_if.B, 32'h3);
        bus_if.stall = 0; bus_if.wbEnable = 0; bus_if.inValid = 0; bus_if.useImm = 0;

        // Flags
        bus_if.flagLoad = 1; bus_if.carryFlag = 1; bus_if.zeroFlag = 1;
        tick();
        check("flag_carry", 32'(bus_if.inputCarry), 32'h1);
        check("flag_status", 32'(bus_if.statusFlags), 32'h6);
        bus_if.flagLoad = 0; bus_if.negativeFlag = 1; bus_if.overflowFlag = 1;
        bus_if.carryFlag = 0; bus_if.zeroFlag = 0;
        tick();
        check("flag_hold", 32'(bus_if.statusFlags), 32'h6);
        bus_if.flagLoad = 1;
        tick();
        check("flag_nv", 32'(bus_if.statusFlags), 32'h9);
        check("flag_nv_carry", 32'(bus_if.inputCarry), 32'h0);
        bus_if.carryFlag = 1; bus_if.zeroFlag = 1;
        bus_if.negativeFlag = 0; bus_if.overflowFlag = 0;

        // Reset mid-stream: asynchronous clear, flagLoad loses to reset
        bus_if.inValid = 1; bus_if.rs = 5; bus_if.rt = 6; bus_if.opcodeIn = OpNor;
        tick();
        check("pre_reset_A", bus_if.A, 32'h55);
        check("pre_reset_flags", 32'(bus_if.statusFlags), 32'h6);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        check_all_zero("reset_vs_flagload");
        bus_if.flagLoad = 0; bus_if.inValid = 0;
        #2;
        reset = 1'b0;
        tick();
        check("post_reset_outValid", 32'(bus_if.outValid), 32'h0);
        bus_if.inValid = 1;
        tick();
        check("post_reset_outValid1", 32'(bus_if.outValid), 32'h1);
        check("post_reset_rf_A", bus_if.A, 32'h0);
        check("post_reset_rf_B", bus_if.B, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/register width.
REQ-002 SHALL have parameter REG_N, default 32, meaning register count (index width 5).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inValid  input  1  instruction fields below valid this cycle.
REQ-006 stall  input  1  downstream ALU stage not accepting; hold output register.
REQ-007 flush  input  1  discard output-register contents (insert bubble).
REQ-008 opcodeIn  input  6  ALU opcode to forward.
REQ-009 rs, rt  input  5 each  source register indices.
REQ-010 useImm  input  1  B taken from immediate instead of R[rt].
REQ-011 immSigned  input  1  1 = sign-extend imm (ADDI/ADDIU), 0 = zero-extend (ANDI/ORI/XORI).
REQ-012 imm  input  16  immediate field.
REQ-013 wbEnable, wbAddr, wbData  input  1/5/32  writeback port from ALU result.
REQ-014 flagLoad  input  1  capture ALU flags this cycle.
REQ-015 negativeFlag, zeroFlag, carryFlag, overflowFlag  input  1 each  ALU flags.
REQ-016 A, B  output  32 each  registered ALU operands.
REQ-017 opcode  output  6  registered ALU opcode.
REQ-018 outValid  output  1  A/B/opcode hold a live instruction.
REQ-019 inputCarry  output  1  stored carry flag, fed to ALU inputCarry.
REQ-020 statusFlags  output  4  stored {N,Z,C,V}.

Function
REQ-021 Register file SHALL hold REG_N x DATA_W words, written on rising edge when wbEnable=1 and wbAddr!=0.
REQ-022 R[0] SHALL read 0 always; writes to index 0 SHALL be ignored.
REQ-023 Read SHALL bypass: if wbEnable=1, wbAddr!=0, wbAddr==rs (rt) in same cycle, operand uses wbData.
REQ-024 B source SHALL be: useImm=1 -> extended imm per immSigned; else R[rt] (with bypass).
REQ-025 Latency SHALL be one cycle: fields presented with inValid=1 appear on A/B/opcode with outValid=1 after next edge.
REQ-026 Priority at each edge SHALL be: flush > stall > load.
REQ-027 flush=1: outValid SHALL become 0 next edge regardless of stall or inValid; A/B/opcode unchanged.
REQ-028 stall=1, flush=0: A/B/opcode/outValid SHALL hold; the new input is dropped (upstream must hold it).
REQ-029 While stalled with outValid=1, a writeback hitting the held rs (or held rt when held useImm=0) SHALL update the held A (B) to wbData next edge; index 0 never refreshes.
REQ-030 stall=0, flush=0: register loads inputs; outValid takes inValid.
REQ-031 Register-file writes SHALL proceed during stall and flush.
REQ-032 flagLoad=1 SHALL capture the four flags next edge; otherwise flags hold.
REQ-033 inputCarry SHALL equal stored carry; statusFlags SHALL be {N,Z,C,V} stored.
REQ-034 Simultaneous flagLoad and reset: reset wins.

Reset
REQ-035 reset=1 SHALL asynchronously clear all register-file entries, A, B, opcode, outValid, stored flags to 0.
REQ-036 Reset mid-operation SHALL discard any held or in-flight instruction; first post-reset outValid requires a new inValid.

Structure
REQ-037 Shared package SHALL hold ALU opcode constants (ADD 000000, SUB 000001, AND 000010, OR 000011, XOR 000100, ADDIU 000101, SLL 000110, SRL 000111, ADDI 001000, NOR 001001, ANDI 001010, ORI 001011, XORI 001100), DATA_W, register index width, flag bit positions.
REQ-038 Register file SHALL be sub-module register_file (2 async read, 1 sync write, r0 zero, async reset); bypass and output register live in alu_operand_stage.

Verification
REQ-039 Write R5=0x00000006, R6=0x0000000A; issue rs=5 rt=6 useImm=0 opcode=000000 -> next edge A=6, B=0x0A, opcode=000000, outValid=1.
REQ-040 Same cycle wbEnable=1 wbAddr=7 wbData=0x12345678 and rs=7 -> next edge A=0x12345678.
REQ-041 useImm=1 imm=0xFFF0: immSigned=1 -> B=0xFFFFFFF0; immSigned=0 -> B=0x0000FFF0.
REQ-042 Write wbAddr=0 wbData=0xDEADBEEF, then read rs=0 -> A=0.
REQ-043 Hold stall=1 with held rs=5, write R5=0x55 -> A=0x55 next edge, outValid stays 1; assert flush with stall -> outValid=0.
REQ-044 flagLoad=1 with carryFlag=1, zeroFlag=1 -> inputCarry=1, statusFlags=0110; assert reset mid-stream -> all outputs 0 immediately, before clock edge.
